// File: rtl/interval_timer_ctrl.sv
// Interval timer for a traffic-light controller: three programmable second-based
// intervals, a one-second prescaler and a restartable countdown with an expiry pulse.
module interval_timer_ctrl #(
   parameter int CLK_PER_SEC = 4,
   parameter int DEF_BASE    = 6,
   parameter int DEF_EXT     = 3,
   parameter int DEF_YEL     = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_timer,
   input  logic [1:0] requesting_interval,
   input  logic [1:0] prog_sel,
   input  logic [3:0] time_value,
   input  logic       reprogram,
   output logic       expired,
   output logic       busy,
   output logic       one_hz_enable,
   output logic [3:0] count_value
);

   // CLK_PER_SEC below 2 has no meaningful prescaler; the width floor only keeps elaboration legal.
   localparam int            PW        = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_PER_SEC - 1);

   localparam logic [1:0] SEL_BASE = 2'b00;
   localparam logic [1:0] SEL_EXT  = 2'b01;
   localparam logic [1:0] SEL_YEL  = 2'b10;

   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } state_t;

   state_t        state, state_n;
   logic [PW-1:0] presc, presc_n;
   logic [3:0]    base_q, base_n;
   logic [3:0]    ext_q, ext_n;
   logic [3:0]    yel_q, yel_n;
   logic [3:0]    count_n;
   logic          expired_n;
   logic          busy_n;
   logic          one_hz_n;
   logic          wrap;

   // A zero-second interval is meaningless, so writes of 0 are stored as 1.
   function automatic logic [3:0] stored_value(input logic [3:0] v);
      return (v == 4'd0) ? 4'd1 : v;
   endfunction

   // The reserved select code falls back to the base interval.
   function automatic logic [3:0] selected_interval(input logic [1:0] sel,
                                                    input logic [3:0] b,
                                                    input logic [3:0] e,
                                                    input logic [3:0] y);
      case (sel)
         SEL_EXT: return e;
         SEL_YEL: return y;
         default: return b;
      endcase
   endfunction

   assign wrap = (state == COUNT) && (presc == PRESC_MAX);

   // Priority: reprogram (write + abort), then start/restart, then normal counting.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      state_n   = state;
      presc_n   = presc;
      base_n    = base_q;
      ext_n     = ext_q;
      yel_n     = yel_q;
      count_n   = count_value;
      expired_n = 1'b0;
      one_hz_n  = 1'b0;

      if (reprogram) begin
         case (prog_sel)
            SEL_BASE: base_n = stored_value(time_value);
            SEL_EXT:  ext_n  = stored_value(time_value);
            SEL_YEL:  yel_n  = stored_value(time_value);
            default:  ;
         endcase
         state_n = IDLE;
         presc_n = '0;
         count_n = 4'd0;
      end else if (start_timer) begin
         state_n = COUNT;
         presc_n = '0;
         count_n = selected_interval(requesting_interval, base_q, ext_q, yel_q);
      end else if (state == COUNT) begin
         if (wrap) begin
            presc_n  = '0;
            one_hz_n = 1'b1;
            if (count_value <= 4'd1) begin
               expired_n = 1'b1;
               state_n   = IDLE;
               count_n   = 4'd0;
            end else begin
               count_n = count_value - 4'd1;
            end
         end else begin
            presc_n = presc + 1'b1;
         end
      end

      busy_n = (state_n == COUNT);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         presc         <= '0;
         base_q        <= 4'(DEF_BASE);
         ext_q         <= 4'(DEF_EXT);
         yel_q         <= 4'(DEF_YEL);
         count_value   <= 4'd0;
         expired       <= 1'b0;
         busy          <= 1'b0;
         one_hz_enable <= 1'b0;
      end else begin
         state         <= state_n;
         presc         <= presc_n;
         base_q        <= base_n;
         ext_q         <= ext_n;
         yel_q         <= yel_n;
         count_value   <= count_n;
         expired       <= expired_n;
         busy          <= busy_n;
         one_hz_enable <= one_hz_n;
      end
   end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: reset/priority vector table, directed
// latency sequences and randomized traffic against a deadline-based reference model.
module tb_interval_timer_ctrl;

   localparam int C = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start_timer;
   logic [1:0] requesting_interval;
   logic [1:0] prog_sel;
   logic [3:0] time_value;
   logic       reprogram;
   logic       expired;
   logic       busy;
   logic       one_hz_enable;
   logic [3:0] count_value;

   interval_timer_ctrl #(
      .CLK_PER_SEC(C),
      .DEF_BASE   (6),
      .DEF_EXT    (3),
      .DEF_YEL    (2)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .start_timer        (start_timer),
      .requesting_interval(requesting_interval),
      .prog_sel           (prog_sel),
      .time_value         (time_value),
      .reprogram          (reprogram),
      .expired            (expired),
      .busy               (busy),
      .one_hz_enable      (one_hz_enable),
      .count_value        (count_value)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a countdown is a start edge plus a deadline N*C edges later.
   int  cyc = 0;
   int  m_regs[3];
   bit  m_active;
   int  m_k;
   int  m_n;
   bit  m_busy, m_exp, m_hz;
   int  m_count;
   int  seq_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_edge(input logic r, input logic st, input logic [1:0] rq,
                             input logic [1:0] ps, input logic [3:0] tv, input logic rp);
      int e;
      cyc++;
      m_hz  = 0;
      m_exp = 0;
      if (!r) begin
         m_regs  = '{6, 3, 2};
         m_active = 0;
         m_busy  = 0;
         m_count = 0;
      end else begin
         e = cyc - m_k;
         if (rp) begin
            if (ps != 2'd3) m_regs[ps] = (tv == 0) ? 1 : int'(tv);
            m_active = 0;
            m_busy   = 0;
            m_count  = 0;
         end else if (st) begin
            m_k      = cyc;
            m_n      = m_regs[(rq == 2'd3) ? 0 : int'(rq)];
            m_active = 1;
            m_busy   = 1;
            m_count  = m_n;
         end else if (m_active) begin
            m_hz    = (e % C == 0);
            m_count = m_n - e / C;
            if (e == m_n * C) begin
               m_exp    = 1;
               m_active = 0;
               m_busy   = 0;
            end
         end else begin
            m_busy  = 0;
            m_count = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic st, input logic [1:0] rq,
                       input logic [1:0] ps, input logic [3:0] tv, input logic rp);
      reset               = r;
      start_timer         = st;
      requesting_interval = rq;
      prog_sel            = ps;
      time_value          = tv;
      reprogram           = rp;
      @(posedge clk);
      model_edge(r, st, rq, ps, tv, rp);
      #1;
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
   endtask

   task automatic check_model();
      check("busy",    32'(busy),          32'(m_busy));
      check("count",   32'(count_value),   32'(m_count));
      check("expired", 32'(expired),       32'(m_exp));
      check("one_hz",  32'(one_hz_enable), 32'(m_hz));
   endtask

   // Idle until expired; returns edges elapsed, or -1 when the bound runs out.
   task automatic wait_expired(input int bound, output int lat);
      lat = -1;
      for (int i = 1; i <= bound; i++) begin
         idle();
         check_model();
         if (seq_q.size() == 0 || seq_q[$] != int'(count_value)) seq_q.push_back(int'(count_value));
         if (expired === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   typedef struct {
      logic       r, st;
      logic [1:0] rq, ps;
      logic [3:0] tv;
      logic       rp;
      logic       e_busy;
      logic [3:0] e_count;
      logic       e_exp, e_hz;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int lat;
      int exp_seq[6];
      bit seen;

      reset = 1'b0; start_timer = 1'b0; requesting_interval = 2'd0;
      prog_sel = 2'd0; time_value = 4'd0; reprogram = 1'b0;

      //             r   st  rq  ps  tv  rp   busy cnt exp hz
      vecs.push_back('{0, 0,  0,  0,  0,  0,  0,   0,  0,  0}); // reset
      vecs.push_back('{0, 1,  0,  1,  7,  1,  0,   0,  0,  0}); // reset beats start+reprogram
      vecs.push_back('{1, 0,  0,  2,  0,  1,  0,   0,  0,  0}); // yel <= 0 -> stored 1
      vecs.push_back('{1, 1,  2,  0,  0,  0,  1,   1,  0,  0}); // start yel
      vecs.push_back('{1, 0,  0,  0,  0,  0,  1,   1,  0,  0});
      vecs.push_back('{1, 0,  0,  0,  0,  0,  1,   1,  0,  0});
      vecs.push_back('{1, 0,  0,  0,  0,  0,  1,   1,  0,  0});
      vecs.push_back('{1, 0,  0,  0,  0,  0,  0,   0,  1,  1}); // terminal tick
      vecs.push_back('{1, 0,  0,  0,  0,  0,  0,   0,  0,  0});
      vecs.push_back('{1, 0,  0,  3,  9,  1,  0,   0,  0,  0}); // reserved write ignored
      vecs.push_back('{1, 1,  3,  0,  0,  0,  1,   6,  0,  0}); // code 11 -> base
      vecs.push_back('{1, 1,  1,  2,  2,  1,  0,   0,  0,  0}); // reprogram beats start, aborts
      vecs.push_back('{1, 0,  0,  0,  0,  0,  0,   0,  0,  0});

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].r, vecs[i].st, vecs[i].rq, vecs[i].ps, vecs[i].tv, vecs[i].rp);
         check($sformatf("vec%0d_busy", i),    32'(busy),          32'(vecs[i].e_busy));
         check($sformatf("vec%0d_count", i),   32'(count_value),   32'(vecs[i].e_count));
         check($sformatf("vec%0d_expired", i), 32'(expired),       32'(vecs[i].e_exp));
         check($sformatf("vec%0d_one_hz", i),  32'(one_hz_enable), 32'(vecs[i].e_hz));
      end

      // Reset for two cycles, then base countdown of 6 s.
      step(1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 2'd0, 4'd0, 1'b0);
      check_model();
      check("rst_all_zero", 32'({busy, expired, one_hz_enable, count_value}), 32'd0);
      step(1'b1, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
      check("base_busy", 32'(busy), 32'd1);
      check("base_count", 32'(count_value), 32'd6);
      wait_expired(100, lat);
      check("base_latency", 32'(lat), 32'd24);

      // Extended reprogrammed to 5 s: latency and count sequence.
      step(1'b1, 1'b0, 2'd0, 2'd1, 4'd5, 1'b1);
      check_model();
      step(1'b1, 1'b1, 2'd1, 2'd0, 4'd0, 1'b0);
      check_model();
      seq_q.delete();
      seq_q.push_back(int'(count_value));
      wait_expired(100, lat);
      check("ext_latency", 32'(lat), 32'd20);
      exp_seq = '{5, 4, 3, 2, 1, 0};
      check("ext_seq_len", 32'(seq_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < seq_q.size(); i++)
         check($sformatf("ext_seq%0d", i), 32'(seq_q[i]), 32'(exp_seq[i]));

      // Yellow started, restarted with base on the 5th edge: yellow never expires.
      step(1'b1, 1'b1, 2'd2, 2'd0, 4'd0, 1'b0);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         idle();
         check_model();
         if (expired) seen = 1;
      end
      step(1'b1, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
      check_model();
      check("restart_no_early_exp", 32'(seen), 32'd0);
      wait_expired(100, lat);
      check("restart_latency", 32'(lat), 32'd24);

      // Reprogram mid-count aborts silently.
      step(1'b1, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
      for (int i = 0; i < 10; i++) idle();
      step(1'b1, 1'b0, 2'd0, 2'd2, 4'd2, 1'b1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_count", 32'(count_value), 32'd0);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         idle();
         if (expired) seen = 1;
      end
      check("abort_no_exp", 32'(seen), 32'd0);

      // Yellow programmed with 0 -> one second.
      step(1'b1, 1'b0, 2'd0, 2'd2, 4'd0, 1'b1);
      step(1'b1, 1'b1, 2'd2, 2'd0, 4'd0, 1'b0);
      wait_expired(100, lat);
      check("yel_zero_latency", 32'(lat), 32'd4);

      // Code 11 behaves as base.
      step(1'b1, 1'b1, 2'd3, 2'd0, 4'd0, 1'b0);
      check("sel11_count", 32'(count_value), 32'd6);
      wait_expired(100, lat);
      check("sel11_latency", 32'(lat), 32'd24);

      // Restart on the terminal-tick edge: no expired, fresh 5 s countdown.
      step(1'b1, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
      for (int i = 0; i < 23; i++) begin
         idle();
         check_model();
      end
      step(1'b1, 1'b1, 2'd1, 2'd0, 4'd0, 1'b0);
      check("term_restart_exp", 32'(expired), 32'd0);
      check("term_restart_busy", 32'(busy), 32'd1);
      check("term_restart_count", 32'(count_value), 32'd5);
      wait_expired(100, lat);
      check("term_restart_latency", 32'(lat), 32'd20);

      // Reset mid-countdown (with start asserted) aborts without expiry.
      step(1'b1, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
      for (int i = 0; i < 5; i++) idle();
      step(1'b0, 1'b1, 2'd0, 2'd0, 4'd0, 1'b0);
      check_model();
      check("rst_mid_busy", 32'(busy), 32'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         idle();
         check_model();
         if (expired) seen = 1;
      end
      check("rst_mid_no_exp", 32'(seen), 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 199) != 0),
              1'($urandom_range(0, 19) == 0),
              2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)),
              1'($urandom_range(0, 39) == 0));
         check_model();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_tests);
      $fatal(1, "timeout");
   end

endmodule
